// File: rtl/instruction_fetch_memory.sv
// instruction_fetch_memory: loadable instruction store with registered fetch port,
// stall/hold, out-of-range detection and an optional NOP sweep of the array after reset.
module instruction_fetch_memory #(
    parameter int                     INSTR_WIDTH    = 19,
    parameter int                     ADDR_WIDTH     = 12,
    parameter int                     DEPTH          = 4096,
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD       = '0,
    parameter bit                     CLEAR_ON_RESET = 1'b1
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   ready,
    input  logic                   load_en,
    input  logic [ADDR_WIDTH-1:0]  load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data,
    input  logic                   fetch_en,
    input  logic [ADDR_WIDTH-1:0]  fetch_addr,
    input  logic                   stall,
    output logic [INSTR_WIDTH-1:0] instruction,
    output logic                   instruction_valid,
    output logic                   addr_error
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   valid_q, valid_d, err_q, err_d;
    logic                   load_ok, fetch_ok, fetch_go;

    assign ready             = state_q == RUN;
    assign instruction       = instr_q;
    assign instruction_valid = valid_q;
    assign addr_error        = err_q;

    always_comb begin
        load_ok  = ready && load_en && ({1'b0, load_addr} < DEPTH_W);
        fetch_ok = {1'b0, fetch_addr} < DEPTH_W;
        fetch_go = ready && !stall;
        state_d  = (state_q == CLEAR && ptr_q == LAST) ? RUN : state_q;
        ptr_d    = state_q == CLEAR ? ptr_q + 1'b1 : ptr_q;
        valid_d  = fetch_go ? fetch_en : valid_q;
        err_d    = fetch_go ? fetch_en && !fetch_ok : err_q;
        instr_d  = instr_q;
        // write-first: a load to the fetched address bypasses the array
        if (fetch_go && fetch_en)
            instr_d = !fetch_ok ? NOP_WORD
                    : (load_ok && load_addr == fetch_addr) ? load_data
                    : mem_q[fetch_addr[IW-1:0]];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= CLEAR_ON_RESET ? CLEAR : RUN;
            ptr_q   <= '0;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state_q == CLEAR)
                mem_q[ptr_q[IW-1:0]] <= NOP_WORD;
            else if (load_ok)
                mem_q[load_addr[IW-1:0]] <= load_data;
        end
    end
endmodule
